// File: rtl/w5300_bus_seq.sv
// W5300 bus sequencer: turns a one-cycle request into a timed cs_n/rd_n/wr_n access
// with setup, strobe, hold and recovery phases, and synchronises the W5300 interrupt.
module w5300_bus_seq #(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 3,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 2,
  parameter int CNT_W       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       rnw,
  input  logic [9:0] req_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       ack,
  output logic [7:0] rdata,
  output logic [9:0] w_addr,
  output logic       w_cs_n,
  output logic       w_rd_n,
  output logic       w_wr_n,
  output logic [7:0] w_d_out,
  output logic       w_d_oe,
  input  logic [7:0] w_d_in,
  input  logic       w_int_n,
  output logic       int_req
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RECOVER
  } state_e;

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'((RECOVER_CYC > 0) ? RECOVER_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rnw_q, rnw_d;
  logic [9:0]       addr_q, addr_d;
  logic [7:0]       dout_q, dout_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             cs_n_q, cs_n_d;
  logic             rd_n_q, rd_n_d;
  logic             wr_n_q, wr_n_d;
  logic             oe_q, oe_d;
  logic             sync1_q, sync2_q;
  logic             cnt_zero;
  logic             active_d;

  assign cnt_zero = (cnt_q == '0);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          rnw_d   = rnw;
          addr_d  = req_addr;
          dout_d  = wdata;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_STROBE: begin
        if (cnt_zero) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
          ack_d   = 1'b1;
          // Bus is sampled on the edge where the strobe rises, while the device still drives it.
          if (rnw_q) rdata_d = w_d_in;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          if (RECOVER_CYC == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RECOVER;
            cnt_d   = RECOVER_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RECOVER: begin
        if (cnt_zero) state_d = S_IDLE;
        else          cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pin values are decoded from the next state so they are registered with it.
    active_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    cs_n_d   = ~active_d;
    rd_n_d   = ~((state_d == S_STROBE) &&  rnw_d);
    wr_n_d   = ~((state_d == S_STROBE) && !rnw_d);
    oe_d     = active_d && !rnw_d;
    busy_d   = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      oe_q    <= oe_d;
      sync1_q <= w_int_n;
      sync2_q <= sync1_q;
    end
  end

  assign busy    = busy_q;
  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign w_addr  = addr_q;
  assign w_cs_n  = cs_n_q;
  assign w_rd_n  = rd_n_q;
  assign w_wr_n  = wr_n_q;
  assign w_d_out = dout_q;
  assign w_d_oe  = oe_q;
  assign int_req = ~sync2_q;

endmodule

// File: tb/tb_w5300_bus_seq.sv
// Randomised scoreboard bench for w5300_bus_seq: a W5300 memory model on the pins,
// a reference memory for expected data, and a protocol monitor for phase timing.
module tb_w5300_bus_seq;

  localparam int A_SETUP = 1, A_STROBE = 3, A_HOLD = 1, A_RECOVER = 2;

  typedef struct {
    logic       rnw;
    logic [9:0] addr;
    logic [7:0] data;
  } acc_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default-parameter instance
  logic       req, rnw, busy, ack, w_cs_n, w_rd_n, w_wr_n, w_d_oe, w_int_n, int_req;
  logic [9:0] req_addr, w_addr;
  logic [7:0] wdata, rdata, w_d_out, w_d_in;

  // fast-parameter instance
  logic       b_req, b_rnw, b_busy, b_ack, b_cs_n, b_rd_n, b_wr_n, b_oe, b_int_n, b_int_req;
  logic [9:0] b_addr, b_w_addr;
  logic [7:0] b_wdata, b_rdata, b_d_out, b_d_in;

  w5300_bus_seq dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rnw(rnw), .req_addr(req_addr), .wdata(wdata),
    .busy(busy), .ack(ack), .rdata(rdata), .w_addr(w_addr), .w_cs_n(w_cs_n),
    .w_rd_n(w_rd_n), .w_wr_n(w_wr_n), .w_d_out(w_d_out), .w_d_oe(w_d_oe),
    .w_d_in(w_d_in), .w_int_n(w_int_n), .int_req(int_req)
  );

  w5300_bus_seq #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(1), .RECOVER_CYC(0), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .rnw(b_rnw), .req_addr(b_addr), .wdata(b_wdata),
    .busy(b_busy), .ack(b_ack), .rdata(b_rdata), .w_addr(b_w_addr), .w_cs_n(b_cs_n),
    .w_rd_n(b_rd_n), .w_wr_n(b_wr_n), .w_d_out(b_d_out), .w_d_oe(b_oe),
    .w_d_in(b_d_in), .w_int_n(b_int_n), .int_req(b_int_req)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc++;

  // W5300 memory model on the pins and the bench's own reference memory
  logic [7:0] bus_mem [1024];
  logic [7:0] ref_mem [1024];
  acc_t exp_q[$];
  acc_t log_q[$];

  assign w_d_in = (!w_cs_n && !w_rd_n) ? bus_mem[w_addr] : 8'hEE;
  assign b_d_in = (!b_rd_n) ? 8'h3C : 8'h00;

  always @(posedge w_wr_n) begin
    if (rst_n === 1'b1) begin
      bus_mem[w_addr] = w_d_out;
      log_q.push_back('{1'b0, w_addr, w_d_out});
    end
  end

  always @(posedge w_rd_n) begin
    if (rst_n === 1'b1) log_q.push_back('{1'b1, w_addr, bus_mem[w_addr]});
  end

  // protocol monitor and scoreboard for the default instance
  bit         in_acc = 0, seen_prev = 0, viol = 0, prev_ack = 0;
  bit         is_read, oe_seen, oe_drop, addr_chg;
  int         cs_fall_cyc = 0, gap = 0, setup_c, strb_c, hold_c;
  logic [9:0] a_addr;
  logic [7:0] last_rd = 8'h00;

  always @(negedge clk) begin
    acc_t e, l;
    if (!rst_n) begin
      in_acc = 0; seen_prev = 0; gap = 0; last_rd = 8'h00; prev_ack = 0;
    end else begin
      if ((!w_rd_n || !w_wr_n) && w_cs_n) viol = 1;
      if (!w_rd_n && !w_wr_n) viol = 1;
      if (ack && prev_ack) viol = 1;
      prev_ack = ack;
      if (!in_acc && !w_cs_n) begin
        in_acc = 1; cs_fall_cyc = cyc;
        if (seen_prev) check("recover_gap", 32'(gap >= A_RECOVER), 1);
        a_addr = w_addr; setup_c = 0; strb_c = 0; hold_c = 0;
        is_read = 0; oe_seen = 0; oe_drop = 0; addr_chg = 0;
      end
      if (in_acc && !w_cs_n) begin
        if (w_addr !== a_addr) addr_chg = 1;
        if (!w_rd_n || !w_wr_n) begin
          strb_c++;
          if (!w_rd_n) is_read = 1;
        end else if (strb_c == 0) setup_c++;
        else hold_c++;
        if (w_d_oe) oe_seen = 1; else oe_drop = 1;
      end
      if (in_acc && w_cs_n) begin
        in_acc = 0; seen_prev = 1; gap = 0;
        check("setup_cycles", setup_c, A_SETUP);
        check("strobe_cycles", strb_c, A_STROBE);
        check("hold_cycles", hold_c, A_HOLD);
        check("addr_stable", addr_chg, 0);
        check("protocol_viol", viol, 0);
        if (is_read) check("oe_during_read", oe_seen, 0);
        else         check("oe_drop_write", oe_drop, 0);
      end
      if (w_cs_n) begin
        gap++;
        if (w_d_oe) viol = 1;
      end
      if (ack) begin
        check("ack_latency", cyc - cs_fall_cyc, A_SETUP + A_STROBE);
        if (exp_q.size() == 0) check("ack_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          if (log_q.size() == 0) check("bus_log_empty", 1, 0);
          else begin
            l = log_q.pop_front();
            check("bus_addr", l.addr, e.addr);
            check("bus_rnw", l.rnw, e.rnw);
            check("bus_data", l.data, e.data);
          end
          if (e.rnw) begin
            check("rdata", rdata, e.data);
            last_rd = e.data;
          end else begin
            check("rdata_kept", rdata, last_rd);
          end
        end
      end
    end
  end

  // timing monitor for the fast instance
  bit b_prev_cs = 1;
  int b_cs_fall = 0, b_run = 0, b_last_width = 0;
  always @(negedge clk) begin
    if (b_prev_cs && !b_cs_n) b_cs_fall = cyc;
    b_prev_cs = b_cs_n;
    if (!b_rd_n || !b_wr_n) b_run++;
    else if (b_run != 0) begin
      b_last_width = b_run;
      b_run = 0;
    end
  end

  // Issue one access from a negedge; returns at the negedge of the ack cycle.
  task automatic do_access(input logic r, input logic [9:0] a, input logic [7:0] d,
                           input bit keep, output int ack_at);
    acc_t e;
    bit   got = 0;
    e.rnw  = r;
    e.addr = a;
    e.data = r ? ref_mem[a] : d;
    if (!r) ref_mem[a] = d;
    exp_q.push_back(e);
    req = 1'b1; rnw = r; req_addr = a; wdata = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack) begin
        got = 1;
        break;
      end
    end
    ack_at = cyc;
    if (!got) begin
      check("ack_timeout", 0, 1);
      void'(exp_q.pop_back());
      ack_at = -1;
    end
    if (!keep || !got) req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   t1, t2;
    bit   got;
    logic r;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 8'($urandom);
      bus_mem[i] = ref_mem[i];
    end
    ref_mem[10'h3FF] = 8'h5C;
    bus_mem[10'h3FF] = 8'h5C;
    rst_n = 1'b0; req = 1'b0; rnw = 1'b0; req_addr = '0; wdata = '0; w_int_n = 1'b1;
    b_req = 1'b0; b_rnw = 1'b0; b_addr = '0; b_wdata = '0; b_int_n = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_cs_n", w_cs_n, 1);
    check("rst_rd_n", w_rd_n, 1);
    check("rst_wr_n", w_wr_n, 1);
    check("rst_oe", w_d_oe, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", w_addr, 0);
    check("rst_dout", w_d_out, 0);
    check("rst_int_req", int_req, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed write then read
    do_access(1'b0, 10'h200, 8'hA5, 0, t1);
    repeat (3) @(negedge clk);
    do_access(1'b1, 10'h3FF, 8'h00, 0, t1);
    repeat (4) @(negedge clk);

    // req held high across ack: write then read back-to-back
    do_access(1'b0, 10'h155, 8'h3A, 1, t1);
    do_access(1'b1, 10'h200, 8'h00, 0, t2);
    check("back_to_back_period", t2 - t1, 8);
    repeat (12) @(negedge clk);

    // interrupt synchroniser while idle
    @(posedge clk); #3 w_int_n = 1'b0;
    @(posedge clk); #1 check("int_assert_edge1", int_req, 0);
    @(posedge clk); #1 check("int_assert_edge2", int_req, 1);
    @(negedge clk);
    fork
      do_access(1'b0, 10'h123, 8'h77, 0, t1);
      begin
        repeat (2) @(posedge clk);
        #3 w_int_n = 1'b1;
        @(posedge clk); #1 check("int_deassert_edge1", int_req, 1);
        @(posedge clk); #1 check("int_deassert_edge2", int_req, 0);
      end
    join
    repeat (4) @(negedge clk);

    // reset asserted in the second strobe cycle of a read
    req = 1'b1; rnw = 1'b1; req_addr = 10'h0AB; wdata = 8'h00;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!w_rd_n) begin
        got = 1;
        break;
      end
    end
    req = 1'b0;
    check("abort_rd_seen", got, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("abort_rd_n", w_rd_n, 1);
    check("abort_cs_n", w_cs_n, 1);
    check("abort_busy", busy, 0);
    check("abort_ack", ack, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_ack", ack, 0);
    do_access(1'b1, 10'h0AB, 8'h00, 0, t1);
    repeat (3) @(negedge clk);

    // randomised traffic
    for (int n = 0; n < 24; n++) begin
      r = 1'($urandom);
      do_access(r, 10'($urandom_range(0, 1023)), 8'($urandom), 0, t1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // fast-parameter instance: back-to-back write then read
    @(negedge clk);
    b_req = 1'b1; b_rnw = 1'b0; b_addr = 10'h055; b_wdata = 8'h11;
    got = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (b_ack) begin
        got = 1;
        break;
      end
    end
    check("b_ack1_seen", got, 1);
    t1 = cyc;
    check("b_ack_latency", cyc - b_cs_fall, 3);
    check("b_addr_hold", b_w_addr, 10'h055);
    check("b_dout_hold", b_d_out, 8'h11);
    check("b_oe_hold", b_oe, 1);
    check("b_busy_hold", b_busy, 1);
    b_rnw = 1'b1; b_addr = 10'h0AA;
    @(negedge clk);
    check("b_strobe_width_wr", b_last_width, 1);
    got = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (b_ack) begin
        got = 1;
        break;
      end
    end
    check("b_ack2_seen", got, 1);
    check("b_period", cyc - t1, 5);
    check("b_rdata", b_rdata, 8'h3C);
    b_req = 1'b0;
    @(negedge clk);
    check("b_strobe_width_rd", b_last_width, 1);
    check("b_int_req", b_int_req, 0);

    // drain: nothing outstanding, nothing extra
    repeat (20) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("bus_log_drained", log_q.size(), 0);
    check("final_protocol_viol", viol, 0);
    check("final_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
